// File: rtl/mem_access_pkg.sv
// Shared types for the memory-access stage and its neighbours (decode, write_back).
// Also holds the access-size alignment rule used by the lane aligner.
package mem_access_pkg;

  typedef enum logic [1:0] {
    ALU_OUT = 2'd0,
    IMM_DAT = 2'd1,
    MEM_DAT = 2'd2,
    PC_NEXT = 2'd3
  } wb_sel_e;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } mem_funct3_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  // Access size lives in funct3[1:0]; unknown sizes are treated as word accesses.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory port: single outstanding request, completed when ready is high.
interface mem_access_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input req, we, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/mem_access_lsu_align.sv
// Combinational lane logic: store replication/strobes, load extract/extend,
// and the misalignment check for the current access size.
module lsu_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  rbytes [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  for (genvar gi = 0; gi < 4; gi++) begin : g_rbyte
    assign rbytes[gi] = rdata[8*gi +: 8];
  end

  assign misaligned = is_misaligned(funct3, byte_off);
  assign sel_byte   = rbytes[byte_off];
  assign sel_half   = byte_off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    wdata = store_data;
    wstrb = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        wdata = {4{store_data[7:0]}};
        wstrb = 4'b0001 << byte_off;
      end
      2'b01: begin
        wdata = {2{store_data[15:0]}};
        wstrb = byte_off[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
    if (!is_store) wstrb = 4'b0000;
  end

  always_comb begin
    case (funct3)
      F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   load_data = {24'h0, sel_byte};
      F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
      F3_HU:   load_data = {16'h0, sel_half};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// RV32I memory-access stage: runs one req/ready data-memory transaction per
// load/store and registers the fields consumed by write_back.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] RESET_PC_NEXT  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [1:0]  wb_sel,
  input  logic [31:0] immediate,
  input  logic [31:0] pc_next,
  input  logic [4:0]  rd_in,
  input  logic        reg_we_in,
  mem_access_if.master dmem,
  output logic        stall_out,
  output logic        valid_out,
  output logic [1:0]  wb_sel_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] immediate_out,
  output logic [31:0] pc_next_out,
  output logic [31:0] mem_data_out,
  output logic [4:0]  rd_out,
  output logic        reg_we_out,
  output logic        misalign_err,
  output logic        bus_err
);

  state_e      state_reg, state_next;
  logic [31:0] addr_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  wstrb_reg;
  logic        we_reg;
  logic        reg_we_pend_reg;
  logic [31:0] timeout_cnt_reg;

  logic        in_access, is_mem, issue, complete, abort, timeout_hit;
  logic [2:0]  align_funct3;
  logic [1:0]  align_off;
  logic [31:0] align_wdata, align_load;
  logic [3:0]  align_wstrb;
  logic        misaligned;

  assign in_access    = (state_reg == ST_ACCESS);
  assign is_mem       = mem_read | mem_write;
  assign timeout_hit  = (TIMEOUT_CYCLES != 0) && (timeout_cnt_reg == TIMEOUT_CYCLES - 1);
  assign issue        = !in_access && valid_in && is_mem && !misaligned;

  // The aligner sees the incoming op in IDLE and the latched op during ACCESS.
  assign align_funct3 = in_access ? funct3_reg : mem_funct3;
  assign align_off    = in_access ? addr_reg[1:0] : alu_result[1:0];

  lsu_align u_align (
    .funct3     (align_funct3),
    .byte_off   (align_off),
    .is_store   (mem_write),
    .store_data (store_data),
    .rdata      (dmem.rdata),
    .wdata      (align_wdata),
    .wstrb      (align_wstrb),
    .load_data  (align_load),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (issue) state_next = ST_ACCESS;
      ST_ACCESS: if (complete || abort) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    dmem.req   = in_access;
    dmem.we    = in_access & we_reg;
    dmem.addr  = {addr_reg[31:2], 2'b00};
    dmem.wdata = wdata_reg;
    dmem.wstrb = wstrb_reg;
    stall_out  = in_access;
    complete   = in_access & dmem.ready;
    abort      = in_access & ~dmem.ready & timeout_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg        <= '0;
      funct3_reg      <= '0;
      wdata_reg       <= '0;
      wstrb_reg       <= '0;
      we_reg          <= 1'b0;
      reg_we_pend_reg <= 1'b0;
      timeout_cnt_reg <= '0;
      valid_out       <= 1'b0;
      wb_sel_out      <= '0;
      alu_result_out  <= '0;
      immediate_out   <= '0;
      pc_next_out     <= RESET_PC_NEXT;
      mem_data_out    <= '0;
      rd_out          <= '0;
      reg_we_out      <= 1'b0;
      misalign_err    <= 1'b0;
      bus_err         <= 1'b0;
    end else begin
      valid_out    <= 1'b0;
      reg_we_out   <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;

      if (in_access && !dmem.ready) timeout_cnt_reg <= timeout_cnt_reg + 32'd1;
      else                          timeout_cnt_reg <= '0;

      if (!in_access && valid_in) begin
        // Pass-through fields double as the payload latch while the access runs.
        wb_sel_out     <= wb_sel;
        alu_result_out <= alu_result;
        immediate_out  <= immediate;
        pc_next_out    <= pc_next;
        rd_out         <= rd_in;
        if (!is_mem) begin
          valid_out    <= 1'b1;
          reg_we_out   <= reg_we_in && (rd_in != 5'd0);
          mem_data_out <= '0;
        end else if (misaligned) begin
          valid_out    <= 1'b1;
          misalign_err <= 1'b1;
          mem_data_out <= '0;
        end else begin
          addr_reg        <= alu_result;
          funct3_reg      <= mem_funct3;
          wdata_reg       <= align_wdata;
          wstrb_reg       <= align_wstrb;
          we_reg          <= mem_write;
          reg_we_pend_reg <= reg_we_in;
        end
      end

      if (complete) begin
        valid_out    <= 1'b1;
        mem_data_out <= we_reg ? 32'h0 : align_load;
        reg_we_out   <= reg_we_pend_reg && (rd_out != 5'd0);
      end else if (abort) begin
        valid_out    <= 1'b1;
        bus_err      <= 1'b1;
        mem_data_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a vector table of single transactions with a
// ready-delay memory responder, plus a reset-during-access sequence.
module tb_mem_access;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int NVEC = 15;

  logic        clk, rst, valid_in, mem_read, mem_write, reg_we_in;
  logic [2:0]  mem_funct3;
  logic [31:0] alu_result, store_data, immediate, pc_next;
  logic [1:0]  wb_sel;
  logic [4:0]  rd_in;
  logic        stall_out, valid_out, reg_we_out, misalign_err, bus_err;
  logic [1:0]  wb_sel_out;
  logic [31:0] alu_result_out, immediate_out, pc_next_out, mem_data_out;
  logic [4:0]  rd_out;

  mem_access_if dmem ();

  mem_access #(.TIMEOUT_CYCLES(4), .RESET_PC_NEXT(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_in       (valid_in),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_funct3     (mem_funct3),
    .alu_result     (alu_result),
    .store_data     (store_data),
    .wb_sel         (wb_sel),
    .immediate      (immediate),
    .pc_next        (pc_next),
    .rd_in          (rd_in),
    .reg_we_in      (reg_we_in),
    .dmem           (dmem),
    .stall_out      (stall_out),
    .valid_out      (valid_out),
    .wb_sel_out     (wb_sel_out),
    .alu_result_out (alu_result_out),
    .immediate_out  (immediate_out),
    .pc_next_out    (pc_next_out),
    .mem_data_out   (mem_data_out),
    .rd_out         (rd_out),
    .reg_we_out     (reg_we_out),
    .misalign_err   (misalign_err),
    .bus_err        (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd_op;
    logic        wr_op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        we;
    int          delay;     // ACCESS cycle on which ready is raised; 0 = never
    logic [31:0] e_mem;
    logic        e_we;
    logic        e_mis;
    logic        e_bus;
    int          e_lat;
    int          e_stall;
    logic        e_req;
    logic        e_dwe;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
  } vec_t;

  vec_t vecs [NVEC];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    valid_in   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_funct3 = 3'b000;
    alu_result = 32'h0;
    store_data = 32'h0;
    wb_sel     = 2'b00;
    immediate  = 32'h0;
    pc_next    = 32'h0;
    rd_in      = 5'd0;
    reg_we_in  = 1'b0;
  endtask

  initial begin
    int          lat, acc, stall_cnt;
    logic        req_seen;
    logic [31:0] exp_addr;

    rst = 1'b1;
    drive_idle();
    dmem.ready = 1'b0;
    dmem.rdata = 32'h0;

    //          rd    wr    f3      addr          sd            rdata         rd     we    dly e_mem         e_we  e_mis e_bus lat st e_req e_dwe e_wdata       e_wstrb
    vecs[0]  = '{1'b0, 1'b0, 3'b000, 32'h0000_0001, 32'h0,        32'h0,        5'd5,  1'b1, 0, 32'h0,        1'b1, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 32'h0,        4'b0000};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_0000, 5'd6, 1'b1, 3, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b0, 4, 3, 1'b1, 1'b0, 32'h0,        4'b0000};
    vecs[2]  = '{1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0,        32'hBEEF_1234, 5'd7, 1'b1, 1, 32'h0000_BEEF, 1'b1, 1'b0, 1'b0, 2, 1, 1'b1, 1'b0, 32'h0,        4'b0000};
    vecs[3]  = '{1'b0, 1'b1, 3'b001, 32'h0000_3002, 32'h0000_ABCD, 32'h0,       5'd0,  1'b0, 1, 32'h0,        1'b0, 1'b0, 1'b0, 2, 1, 1'b1, 1'b1, 32'hABCD_ABCD, 4'b1100};
    vecs[4]  = '{1'b1, 1'b0, 3'b010, 32'h0000_4001, 32'h0,        32'h0,        5'd7,  1'b1, 1, 32'h0,        1'b0, 1'b1, 1'b0, 1, 0, 1'b0, 1'b0, 32'h0,        4'b0000};
    vecs[5]  = '{1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0,        32'h1111_1111, 5'd8, 1'b1, 0, 32'h0,        1'b0, 1'b0, 1'b1, 5, 4, 1'b1, 1'b0, 32'h0,        4'b0000};
    vecs[6]  = '{1'b1, 1'b0, 3'b000, 32'h0000_1001, 32'h0,        32'h0000_7F00, 5'd9, 1'b1, 1, 32'h0000_007F, 1'b1, 1'b0, 1'b0, 2, 1, 1'b1, 1'b0, 32'h0,        4'b0000};
    vecs[7]  = '{1'b0, 1'b1, 3'b000, 32'h0000_1002, 32'h1234_5678, 32'h0,       5'd0,  1'b0, 1, 32'h0,        1'b0, 1'b0, 1'b0, 2, 1, 1'b1, 1'b1, 32'h7878_7878, 4'b0100};
    vecs[8]  = '{1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0,        32'h8001_0000, 5'd10, 1'b1, 1, 32'hFFFF_8001, 1'b1, 1'b0, 1'b0, 2, 1, 1'b1, 1'b0, 32'h0,       4'b0000};
    vecs[9]  = '{1'b0, 1'b0, 3'b000, 32'hDEAD_BEEF, 32'h0,        32'h0,        5'd0,  1'b1, 0, 32'h0,        1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 32'h0,        4'b0000};
    vecs[10] = '{1'b0, 1'b1, 3'b010, 32'h0000_6000, 32'hCAFE_BABE, 32'h0,       5'd0,  1'b0, 1, 32'h0,        1'b0, 1'b0, 1'b0, 2, 1, 1'b1, 1'b1, 32'hCAFE_BABE, 4'b1111};
    vecs[11] = '{1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'h0,        32'h1234_5678, 5'd11, 1'b1, 2, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 3, 2, 1'b1, 1'b0, 32'h0,       4'b0000};
    vecs[12] = '{1'b1, 1'b0, 3'b100, 32'h0000_8003, 32'h0,        32'h8000_0000, 5'd12, 1'b1, 1, 32'h0000_0080, 1'b1, 1'b0, 1'b0, 2, 1, 1'b1, 1'b0, 32'h0,       4'b0000};
    vecs[13] = '{1'b0, 1'b1, 3'b001, 32'h0000_3001, 32'h0000_5555, 32'h0,       5'd0,  1'b0, 1, 32'h0,        1'b0, 1'b1, 1'b0, 1, 0, 1'b0, 1'b0, 32'h0,        4'b0000};
    vecs[14] = '{1'b1, 1'b0, 3'b101, 32'h0000_9000, 32'h0,        32'h0000_F00D, 5'd13, 1'b1, 4, 32'h0000_F00D, 1'b1, 1'b0, 1'b0, 5, 4, 1'b1, 1'b0, 32'h0,       4'b0000};

    repeat (2) @(negedge clk);
    check("rst_valid_out",   32'(valid_out),    32'h0);
    check("rst_reg_we_out",  32'(reg_we_out),   32'h0);
    check("rst_pc_next_out", pc_next_out,       RST_PC);
    check("rst_dmem_req",    32'(dmem.req),     32'h0);
    check("rst_dmem_addr",   dmem.addr,         32'h0);
    check("rst_stall_out",   32'(stall_out),    32'h0);
    check("rst_mem_data",    mem_data_out,      32'h0);
    check("rst_errs",        {30'h0, misalign_err, bus_err}, 32'h0);

    rst = 1'b0;
    @(negedge clk);
    check("idle_valid_out", 32'(valid_out), 32'h0);
    $display("reset: valid_out=%b pc_next_out=%h dmem_req=%b", valid_out, pc_next_out, dmem.req);

    for (int i = 0; i < NVEC; i++) begin
      valid_in   = 1'b1;
      mem_read   = vecs[i].rd_op;
      mem_write  = vecs[i].wr_op;
      mem_funct3 = vecs[i].f3;
      alu_result = vecs[i].addr;
      store_data = vecs[i].sd;
      wb_sel     = i[1:0];
      immediate  = 32'(i * 16);
      pc_next    = 32'h1000 + 32'(i * 4);
      rd_in      = vecs[i].rd;
      reg_we_in  = vecs[i].we;
      exp_addr   = {vecs[i].addr[31:2], 2'b00};
      @(negedge clk);
      drive_idle();

      lat = 1; acc = 0; stall_cnt = 0; req_seen = 1'b0;
      while (!valid_out && lat < 40) begin
        if (dmem.req) begin
          req_seen = 1'b1;
          acc++;
          if (stall_out) stall_cnt++;
          check($sformatf("v%0d_dmem_addr", i),  dmem.addr,           exp_addr);
          check($sformatf("v%0d_dmem_we", i),    32'(dmem.we),        32'(vecs[i].e_dwe));
          check($sformatf("v%0d_dmem_wstrb", i), 32'(dmem.wstrb),     32'(vecs[i].e_wstrb));
          if (vecs[i].e_dwe)
            check($sformatf("v%0d_dmem_wdata", i), dmem.wdata, vecs[i].e_wdata);
          dmem.ready = (vecs[i].delay != 0) && (acc == vecs[i].delay);
          dmem.rdata = vecs[i].rdata;
        end
        @(negedge clk);
        dmem.ready = 1'b0;
        lat++;
      end

      check($sformatf("v%0d_valid_out", i),  32'(valid_out),      32'h1);
      check($sformatf("v%0d_latency", i),    32'(lat),            32'(vecs[i].e_lat));
      check($sformatf("v%0d_stall_cyc", i),  32'(stall_cnt),      32'(vecs[i].e_stall));
      check($sformatf("v%0d_req_seen", i),   32'(req_seen),       32'(vecs[i].e_req));
      check($sformatf("v%0d_mem_data", i),   mem_data_out,        vecs[i].e_mem);
      check($sformatf("v%0d_reg_we_out", i), 32'(reg_we_out),     32'(vecs[i].e_we));
      check($sformatf("v%0d_misalign", i),   32'(misalign_err),   32'(vecs[i].e_mis));
      check($sformatf("v%0d_bus_err", i),    32'(bus_err),        32'(vecs[i].e_bus));
      check($sformatf("v%0d_alu_out", i),    alu_result_out,      vecs[i].addr);
      check($sformatf("v%0d_rd_out", i),     32'(rd_out),         32'(vecs[i].rd));
      check($sformatf("v%0d_imm_out", i),    immediate_out,       32'(i * 16));
      check($sformatf("v%0d_pc_out", i),     pc_next_out,         32'h1000 + 32'(i * 4));
      check($sformatf("v%0d_wb_sel_out", i), 32'(wb_sel_out),     32'(i % 4));
      $display("vec %0d: addr=%h mem_data=%h reg_we=%b mis=%b bus=%b lat=%0d stalls=%0d",
               i, vecs[i].addr, mem_data_out, reg_we_out, misalign_err, bus_err, lat, stall_cnt);

      @(negedge clk);
      check($sformatf("v%0d_pulse_valid", i), 32'(valid_out),    32'h0);
      check($sformatf("v%0d_pulse_errs", i),  {30'h0, misalign_err, bus_err}, 32'h0);
      check($sformatf("v%0d_back_idle", i),   32'(dmem.req),     32'h0);
    end

    // Reset asserted mid-ACCESS must drop the request without waiting for a clock.
    valid_in   = 1'b1;
    mem_read   = 1'b1;
    mem_funct3 = 3'b010;
    alu_result = 32'h0000_A000;
    rd_in      = 5'd3;
    reg_we_in  = 1'b1;
    pc_next    = 32'h0000_2222;
    @(negedge clk);
    drive_idle();
    check("rstmid_req_before", 32'(dmem.req), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("rstmid_req_dropped", 32'(dmem.req),  32'h0);
    check("rstmid_stall",       32'(stall_out), 32'h0);
    check("rstmid_valid_out",   32'(valid_out), 32'h0);
    check("rstmid_pc_next",     pc_next_out,    RST_PC);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_discarded",   32'(valid_out), 32'h0);
    check("rstmid_req_after",   32'(dmem.req),  32'h0);
    $display("reset mid-access: dmem_req=%b valid_out=%b", dmem.req, valid_out);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
